// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller driving one shared MC14495-style hex decoder
// across NUM_DIGITS common-anode digits, with a double-buffered frame.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 2,
  localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   point_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    zsupp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [3:0]              dec_d,
  output logic                    dec_le,
  output logic                    dec_point,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int TICK_W = $clog2(SCAN_DIV);

  logic [TICK_W-1:0]            tick;
  logic [IDX_W-1:0]             idx;
  logic [NUM_DIGITS-1:0][3:0]   hexShadow, hexActive;
  logic [NUM_DIGITS-1:0]        pointShadow, pointActive;
  logic [NUM_DIGITS-1:0]        blankShadow, blankActive;
  logic                         pending;

  logic                         slotEnd, lastDigit, boundary;
  logic [NUM_DIGITS-1:0]        zeroMask;
  logic                         digitVisible_p0, lit_p0;
  logic [NUM_DIGITS-1:0]        anNext_p0;

  // Bit i set when digit i and every digit to its left hold zero; digit 0 never qualifies.
  function automatic logic [NUM_DIGITS-1:0] leadZeroMask(input logic [NUM_DIGITS-1:0][3:0] hex);
    logic [NUM_DIGITS-1:0] m;
    logic                  allZero;
    m       = '0;
    allZero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      allZero = allZero && (hex[i] == 4'h0);
      m[i]    = allZero;
    end
    return m;
  endfunction

  assign slotEnd   = (tick == TICK_W'(SCAN_DIV - 1));
  assign lastDigit = (idx == IDX_W'(NUM_DIGITS - 1));
  assign boundary  = slotEnd && lastDigit && en;

  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= '0;
      idx  <= '0;
    end else if (en) begin
      if (slotEnd) begin
        tick <= '0;
        idx  <= lastDigit ? '0 : idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
    end
  end

  // Active takes the shadow as it stood before this edge, so a coincident load waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      hexShadow   <= '0;
      pointShadow <= '0;
      blankShadow <= '0;
      hexActive   <= '0;
      pointActive <= '0;
      blankActive <= '0;
      pending     <= 1'b0;
    end else begin
      if (boundary && pending) begin
        hexActive   <= hexShadow;
        pointActive <= pointShadow;
        blankActive <= blankShadow;
      end
      if (load) begin
        hexShadow   <= hex_in;
        pointShadow <= point_in;
        blankShadow <= blank_in;
        pending     <= 1'b1;
      end else if (boundary) begin
        pending     <= 1'b0;
      end
    end
  end

  // p0: decode current slot into next pin values
  always_comb begin
    zeroMask        = leadZeroMask(hexActive);
    digitVisible_p0 = !blankActive[idx] && !(zsupp && zeroMask[idx]);
    lit_p0          = en && (int'(tick) >= BLANK_CYCLES) && digitVisible_p0;
    anNext_p0       = lit_p0 ? ~(NUM_DIGITS'(1) << idx) : '1;
  end

  // p1: registered pins
  always_ff @(posedge clk) begin
    if (rst) begin
      an         <= '1;
      dec_le     <= 1'b1;
      dec_d      <= 4'h0;
      dec_point  <= 1'b0;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      an         <= anNext_p0;
      dec_le     <= !lit_p0;
      dec_d      <= hexActive[idx];
      dec_point  <= pointActive[idx];
      digit_idx  <= idx;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomised plus scenario-driven bench for seg7_scan_ctrl; a frame-position
// reference model feeds a scoreboard queue drained by an independent monitor.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1, en = 1'b0, load = 1'b0, zsupp = 1'b0;
  logic [15:0] hexIn = '0;
  logic [3:0]  pointIn = '0, blankIn = '0;
  logic [3:0]  an;
  logic [3:0]  dec_d;
  logic        dec_le, dec_point, frame_done;
  logic [1:0]  digit_idx;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .hex_in(hexIn),
    .point_in(pointIn), .blank_in(blankIn), .zsupp(zsupp),
    .an(an), .dec_d(dec_d), .dec_le(dec_le), .dec_point(dec_point),
    .digit_idx(digit_idx), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic       le;
    logic [3:0] d;
    logic       pt;
    logic [1:0] di;
    logic       fd;
  } obs_t;

  obs_t expQ[$];
  int   nCompared   = 0;
  int   nMismatched = 0;

  // Reference model: position within the frame plus the two buffers.
  int          mP = 0;
  logic [15:0] mHexS = '0, mHexA = '0;
  logic [3:0]  mPtS = '0, mPtA = '0, mBlkS = '0, mBlkA = '0;
  bit          mPend = 0;

  logic [15:0] curHex = '0;
  logic [3:0]  curPt = '0, curBk = '0;
  logic        curZs = 1'b0;

  task automatic step(input bit r, input bit e, input bit l);
    obs_t x;
    int   tk, i;
    bit   vis, lit;
    @(negedge clk);
    rst = r; en = e; load = l;
    hexIn = curHex; pointIn = curPt; blankIn = curBk; zsupp = curZs;
    if (r) begin
      x.an = 4'hF; x.le = 1'b1; x.d = 4'h0; x.pt = 1'b0; x.di = 2'd0; x.fd = 1'b0;
      mP = 0; mHexS = '0; mHexA = '0; mPtS = '0; mPtA = '0;
      mBlkS = '0; mBlkA = '0; mPend = 0;
    end else begin
      tk  = mP % SD;
      i   = mP / SD;
      vis = !mBlkA[i] && !(curZs && i != 0 && ((mHexA >> (4 * i)) == 16'h0));
      lit = e && (tk >= BC) && vis;
      x.an = lit ? ~(4'b0001 << i) : 4'hF;
      x.le = !lit;
      x.d  = mHexA[4*i +: 4];
      x.pt = mPtA[i];
      x.di = 2'(i);
      x.fd = e && (mP == FRAME - 1);
      if (x.fd && mPend) begin
        mHexA = mHexS; mPtA = mPtS; mBlkA = mBlkS; mPend = 0;
      end
      if (l) begin
        mHexS = curHex; mPtS = curPt; mBlkS = curBk; mPend = 1;
      end
      if (e) mP = (mP + 1) % FRAME;
    end
    expQ.push_back(x);
  endtask

  task automatic run(input int n);
    repeat (n) step(0, 1, 0);
  endtask

  task automatic waitPos(input int target);
    for (int k = 0; k < 2 * FRAME && mP != target; k++) step(0, 1, 0);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a.an = an; a.le = dec_le; a.d = dec_d; a.pt = dec_point;
        a.di = digit_idx; a.fd = frame_done;
        nCompared++;
        if (a !== e) begin
          nMismatched++;
          $display("FAIL scan @%0t: got an=%b le=%b d=%h pt=%b idx=%0d fd=%b, required an=%b le=%b d=%h pt=%b idx=%0d fd=%b",
                   $time, a.an, a.le, a.d, a.pt, a.di, a.fd, e.an, e.le, e.d, e.pt, e.di, e.fd);
        end
      end
    end
  end

  initial begin : stimulus
    repeat (3) step(1, 1, 0);
    run(40);

    curHex = 16'h1234; curPt = 4'b0100;
    step(0, 1, 1);
    run(80);

    waitPos(SD + 3);
    curHex = 16'hABCD; curPt = 4'b0000;
    step(0, 1, 1);
    run(40);
    waitPos(FRAME - 1);
    curHex = 16'h5678;
    step(0, 1, 1);
    run(70);

    curZs = 1'b1; curHex = 16'h0040;
    step(0, 1, 1);
    run(70);
    curHex = 16'h0000;
    step(0, 1, 1);
    run(70);

    curZs = 1'b0; curHex = 16'h9876; curBk = 4'b0010;
    step(0, 1, 1);
    run(70);

    curBk = 4'b0000; curHex = 16'hC3A5; curPt = 4'b1001;
    step(0, 1, 1);
    run(40);
    waitPos(2 * SD + 5);
    repeat (10) step(0, 0, 0);
    run(30);
    waitPos(3 * SD + 2);
    step(1, 1, 0);
    run(10);

    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 4; k++)
        curHex[4*k +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      curPt = 4'($urandom);
      curBk = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 31) == 0) curZs = ~curZs;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 15) == 0);
    end

    @(posedge clk);
    #2;
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("FAIL drain: %0d expected observations left, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
